link_tx_arbiter: RTL and testbench

Shares the single UART transmit line (UART_TX, 8N1, LSB first) between two byte producers: requester 0, the link port's SB/SC serial transfer, and requester 1, the debug trace console. The block contains a round-robin arbiter, a data latch, a baud divider driven from the system clock, and a start/data/stop frame sequencer. It sits between the memory-mapped link peripheral, the trace unit and the board's UART-to-USB pin. It replaces the separate 115200 Hz clock domain with a tick generated inside the system clock domain.

---
 rtl/link_pkg.sv | 17 +
 rtl/uart_tx_frame.sv | 94 +++++++++
 rtl/link_tx_arbiter.sv | 69 ++++++
 tb/tb_link_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared types and constants for the link/trace UART transmit path.
// Also holds the link register addresses used by the adjacent peripheral.
package link_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int CLKS_PER_BIT_DEF = 36;

   localparam logic [15:0] ADDR_SB = 16'hff01;
   localparam logic [15:0] ADDR_SC = 16'hff02;

endpackage

// File: rtl/uart_tx_frame.sv
// 8N1 frame sequencer: baud counter, bit counter, shift register and FSM.
// A start pulse in IDLE latches data and drives the start bit at once.
module uart_tx_frame
   import link_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clock4,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

   tx_state_t  state, state_n;
   logic [7:0] baud, baud_n;
   logic [2:0] bit_cnt, bit_n;
   logic [7:0] sh, sh_n;
   logic       tx_n;
   logic       wrap;

   assign wrap = (baud == LAST);
   assign busy = (state != IDLE);
   assign done = (state == STOP) && wrap;

   always_ff @(posedge clock4 or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         sh      <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_cnt <= bit_n;
         sh      <= sh_n;
         tx      <= tx_n;
      end
   end

   // Line level is registered, so each transition sets the next bit's level.
   always_comb begin
      state_n = state;
      baud_n  = baud + 8'd1;
      bit_n   = bit_cnt;
      sh_n    = sh;
      tx_n    = tx;
      unique case (state)
         IDLE: begin
            baud_n = '0;
            tx_n   = 1'b1;
            if (start) begin
               state_n = START;
               sh_n    = data;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (wrap) begin
               state_n = DATA;
               baud_n  = '0;
               bit_n   = '0;
               tx_n    = sh[0];
            end
         end
         DATA: begin
            if (wrap) begin
               baud_n = '0;
               if (bit_cnt == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n = bit_cnt + 3'd1;
                  sh_n  = {1'b0, sh[7:1]};
                  tx_n  = sh[1];
               end
            end
         end
         STOP: begin
            if (wrap) begin
               state_n = IDLE;
               baud_n  = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: rtl/link_tx_arbiter.sv
// Round-robin share of one UART TX line between the link port and trace.
// Arbitration, ack pulses and done_id live here; framing is in uart_tx_frame.
module link_tx_arbiter
   import link_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clock4,
   input  logic       resetn,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       busy,
   output logic       done,
   output logic       done_id,
   output logic       UART_TX
);

   logic last_grant;
   logic grant_id;
   logic gnt;
   logic gnt_valid;

   assign gnt_valid = !busy && (req0 || req1);

   // On a tie the requester that did not win last time goes next.
   always_comb begin
      gnt = 1'b0;
      unique case (1'b1)
         req0 && req1:  gnt = ~last_grant;
         req1 && !req0: gnt = 1'b1;
         default:       gnt = 1'b0;
      endcase
   end

   always_ff @(posedge clock4 or negedge resetn) begin
      if (!resetn) begin
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
      end else begin
         ack0 <= gnt_valid && !gnt;
         ack1 <= gnt_valid && gnt;
         if (gnt_valid) begin
            last_grant <= gnt;
            grant_id   <= gnt;
         end
      end
   end

   assign done_id = done & grant_id;

   uart_tx_frame #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_frame (
      .clock4(clock4),
      .resetn(resetn),
      .start (gnt_valid),
      .data  (gnt ? data1 : data0),
      .tx    (UART_TX),
      .busy  (busy),
      .done  (done)
   );

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Bench for link_tx_arbiter: frame vectors, corner sequences and a
// randomized run checked against a queue-based round-robin model.
module tb_link_tx_arbiter;

   logic       clock4 = 1'b0;
   logic       resetn = 1'b0;
   logic       req0 = 1'b0;
   logic [7:0] data0 = '0;
   logic       ack0;
   logic       req1 = 1'b0;
   logic [7:0] data1 = '0;
   logic       ack1;
   logic       busy;
   logic       done;
   logic       done_id;
   logic       UART_TX;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_ack0 = 0;
   int n_ack1 = 0;

   typedef struct {
      bit         id;
      logic [7:0] d;
      logic [9:0] line;
   } vec_t;

   vec_t vecs[4];

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] m0[$];
   logic [7:0] m1[$];
   logic [8:0] exp_q[$];
   logic [7:0] mon_q[$];
   logic       done_q[$];
   logic       mon_en = 1'b0;
   logic       prev_tx = 1'b1;
   logic [7:0] mon_byte;

   link_tx_arbiter #(
      .CLKS_PER_BIT(4)
   ) dut (
      .clock4 (clock4),
      .resetn (resetn),
      .req0   (req0),
      .data0  (data0),
      .ack0   (ack0),
      .req1   (req1),
      .data1  (data1),
      .ack1   (ack1),
      .busy   (busy),
      .done   (done),
      .done_id(done_id),
      .UART_TX(UART_TX)
   );

   always #5 clock4 = ~clock4;

   always @(posedge clock4) cyc++;

   always @(negedge clock4) begin
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
   end

   // Line decoder: samples mid-bit after each detected start edge.
   always begin
      @(negedge clock4);
      if (mon_en && resetn && prev_tx && !UART_TX) begin
         mon_byte = '0;
         repeat (5) @(negedge clock4);
         for (int i = 0; i < 8; i++) begin
            mon_byte[i] = UART_TX;
            if (i < 7) repeat (4) @(negedge clock4);
         end
         repeat (4) @(negedge clock4);
         mon_q.push_back(mon_byte);
      end
      prev_tx = UART_TX;
   end

   always @(negedge clock4) begin
      if (mon_en && done) done_q.push_back(done_id);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_ack(input bit id, output int t);
      t = 0;
      do begin
         @(negedge clock4);
         t++;
      end while (!(id ? ack1 : ack0) && t < 200);
   endtask

   // Entered at the negedge where the ack was seen (frame cycle 0).
   task automatic check_frame(input string nm, input bit id,
                              input logic [9:0] line);
      int bad = 0;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clock4);
         if (UART_TX !== line[9 - k / 4]) bad++;
         if (done !== (k == 39)) bad++;
         if (k == 39) chk({nm, "_done_id"}, done_id, id);
      end
      chk({nm, "_line"}, bad, 0);
   endtask

   task automatic wait_idle(input int lim);
      int t = 0;
      while (busy && t < lim) begin
         @(negedge clock4);
         t++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   initial begin
      int t;
      int bad;
      int a0;
      int a1;
      int ids[6];
      int tms[6];
      int na;
      bit mlast;
      bit pick;

      vecs[0] = '{1'b0, 8'hA5, 10'b0101001011};
      vecs[1] = '{1'b1, 8'h3C, 10'b0001111001};
      vecs[2] = '{1'b0, 8'h00, 10'b0000000001};
      vecs[3] = '{1'b1, 8'hFF, 10'b0111111111};

      // Reset state
      repeat (3) @(negedge clock4);
      chk("rst_tx", UART_TX, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_done", done, 0);
      resetn = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clock4);
         if (UART_TX !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("idle_100", bad, 0);

      // Single-frame vectors
      foreach (vecs[v]) begin
         if (vecs[v].id) begin
            req1 = 1'b1;
            data1 = vecs[v].d;
         end else begin
            req0 = 1'b1;
            data0 = vecs[v].d;
         end
         wait_ack(vecs[v].id, t);
         chk($sformatf("vec%0d_lat", v), t, 1);
         chk($sformatf("vec%0d_other", v),
             vecs[v].id ? ack0 : ack1, 0);
         chk($sformatf("vec%0d_busy", v), busy, 1);
         req0 = 1'b0;
         req1 = 1'b0;
         check_frame($sformatf("vec%0d", v), vecs[v].id, vecs[v].line);
         @(negedge clock4);
         chk($sformatf("vec%0d_end_busy", v), busy, 0);
         chk($sformatf("vec%0d_end_tx", v), UART_TX, 1);
      end

      // Simultaneous requests
      a0 = n_ack0;
      a1 = n_ack1;
      req0 = 1'b1;
      data0 = 8'h01;
      req1 = 1'b1;
      data1 = 8'h80;
      wait_ack(1'b0, t);
      chk("sim_lat", t, 1);
      chk("sim_ack1_early", ack1, 0);
      req0 = 1'b0;
      check_frame("sim0", 1'b0, 10'b0100000001);
      @(negedge clock4);
      chk("sim_gap_tx", UART_TX, 1);
      chk("sim_gap_ack1", ack1, 0);
      @(negedge clock4);
      chk("sim_ack1", ack1, 1);
      req1 = 1'b0;
      check_frame("sim1", 1'b1, 10'b0000000011);
      @(negedge clock4);
      chk("sim_n_ack0", n_ack0 - a0, 1);
      chk("sim_n_ack1", n_ack1 - a1, 1);

      // Fairness with both requests held
      req0 = 1'b1;
      data0 = 8'h55;
      req1 = 1'b1;
      data1 = 8'hAA;
      na = 0;
      t = 0;
      while (na < 6 && t < 400) begin
         @(negedge clock4);
         t++;
         if (ack0 || ack1) begin
            ids[na] = ack1 ? 1 : 0;
            tms[na] = cyc;
            na++;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      chk("fair_count", na, 6);
      for (int i = 0; i < na; i++) begin
         chk($sformatf("fair_id%0d", i), ids[i], i % 2);
         if (i > 0)
            chk($sformatf("fair_gap%0d", i), tms[i] - tms[i-1], 41);
      end
      wait_idle(60);
      @(negedge clock4);

      // Reset during data bit 3
      req0 = 1'b1;
      data0 = 8'hFF;
      wait_ack(1'b0, t);
      chk("mid_lat", t, 1);
      req0 = 1'b0;
      repeat (17) @(negedge clock4);
      chk("mid_pre_tx", UART_TX, 1);
      chk("mid_pre_busy", busy, 1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_tx", UART_TX, 1);
      chk("mid_rst_busy", busy, 0);
      bad = 0;
      repeat (3) begin
         @(negedge clock4);
         if (done !== 1'b0 || UART_TX !== 1'b1) bad++;
      end
      resetn = 1'b1;
      repeat (2) begin
         @(negedge clock4);
         if (done !== 1'b0 || UART_TX !== 1'b1) bad++;
      end
      chk("mid_quiet", bad, 0);
      req1 = 1'b1;
      data1 = 8'h3C;
      wait_ack(1'b1, t);
      chk("mid_new_lat", t, 1);
      req1 = 1'b0;
      check_frame("mid_new", 1'b1, 10'b0001111001);
      @(negedge clock4);

      // Withdrawn request during a busy frame
      a1 = n_ack1;
      req0 = 1'b1;
      data0 = 8'h00;
      wait_ack(1'b0, t);
      req0 = 1'b0;
      repeat (10) @(negedge clock4);
      req1 = 1'b1;
      data1 = 8'h77;
      @(negedge clock4);
      req1 = 1'b0;
      wait_idle(60);
      bad = 0;
      repeat (20) begin
         @(negedge clock4);
         if (UART_TX !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("wd_idle", bad, 0);
      chk("wd_no_ack1", n_ack1 - a1, 0);

      // Randomized rounds against the round-robin model
      resetn = 1'b0;
      repeat (2) @(negedge clock4);
      resetn = 1'b1;
      @(negedge clock4);
      mlast = 1'b1;
      mon_en = 1'b1;
      for (int r = 0; r < 8; r++) begin
         q0.delete();
         q1.delete();
         repeat ($urandom_range(0, 3)) q0.push_back(8'($urandom));
         repeat ($urandom_range(0, 3)) q1.push_back(8'($urandom));
         m0 = q0;
         m1 = q1;
         while (m0.size() != 0 || m1.size() != 0) begin
            if (m0.size() != 0 && m1.size() != 0) pick = !mlast;
            else pick = (m1.size() != 0);
            if (pick) exp_q.push_back({1'b1, m1.pop_front()});
            else exp_q.push_back({1'b0, m0.pop_front()});
            mlast = pick;
         end
         req0 = (q0.size() != 0);
         if (req0) data0 = q0[0];
         req1 = (q1.size() != 0);
         if (req1) data1 = q1[0];
         t = 0;
         do begin
            @(negedge clock4);
            t++;
            if (ack0 && q0.size() != 0) void'(q0.pop_front());
            if (ack1 && q1.size() != 0) void'(q1.pop_front());
            req0 = (q0.size() != 0);
            if (req0) data0 = q0[0];
            req1 = (q1.size() != 0);
            if (req1) data1 = q1[0];
         end while ((q0.size() != 0 || q1.size() != 0 || busy)
                    && t < 1000);
         chk($sformatf("rnd%0d_timeout", r), t < 1000, 1);
         repeat ($urandom_range(0, 5)) @(negedge clock4);
      end
      repeat (10) @(negedge clock4);
      mon_en = 1'b0;
      chk("rnd_frames", mon_q.size(), exp_q.size());
      chk("rnd_dones", done_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < mon_q.size())
            chk($sformatf("rnd_byte%0d", i), mon_q[i], exp_q[i][7:0]);
         if (i < done_q.size())
            chk($sformatf("rnd_id%0d", i), done_q[i], exp_q[i][8]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
